button_pio_dbnc: RTL

- Parametrised successor of the 4-bit button PIO: a memory-mapped input port with WIDTH channels.
- Each channel has a synchroniser and a per-channel debounce counter.
- Edge capture is selectable per bit as rising, falling or both, with write-1-to-clear.
- Sits on the Avalon-MM peripheral bus between the board push-buttons/DIP switches and the CPU; irq goes to the CPU interrupt controller.

---
 rtl/button_pio_dbnc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/button_pio_dbnc.sv
`default_nettype none
// ============================================================================
// button_pio_dbnc : Avalon-MM input port with per-channel synchroniser,
//                   debounce and selectable rise/fall edge capture.
// Revision        : 1.0
// ============================================================================
module button_pio_dbnc #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [2:0] c_addr_data = 3'd0;
   localparam logic [2:0] c_addr_sync = 3'd1;
   localparam logic [2:0] c_addr_mask = 3'd2;
   localparam logic [2:0] c_addr_edge = 3'd3;
   localparam logic [2:0] c_addr_rise = 3'd4;
   localparam logic [2:0] c_addr_fall = 3'd5;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_event;
   logic [WIDTH-1:0] w_wdata;
   logic             w_wr;
   logic             w_unused_wdata;

   assign w_sync         = sync_q[SYNC_STAGES-1];
   assign w_wr           = chipselect & ~write_n;
   assign w_wdata        = writedata[WIDTH-1:0];
   assign w_unused_wdata = ^writedata;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
   end

   generate
      if (DEBOUNCE_CYCLES > 0) begin : g_debounce
         localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

         // Any return to the accepted level restarts the qualification count.
         always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            for (int i = 0; i < WIDTH; i++) begin
               if (w_sync[i] == stable_q[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == c_cnt_last) begin
                  stable_d[i] = w_sync[i];
                  cnt_d[i]    = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end else begin : g_bypass
         always_comb begin
            stable_d = w_sync;
         end
      end
   endgenerate

   assign w_rise  = stable_q & ~prev_q;
   assign w_fall  = ~stable_q & prev_q;
   assign w_event = (w_rise & rise_en_q) | (w_fall & fall_en_q);

   // New events are OR-ed in after the clear so a colliding set always wins.
   always_comb begin
      prev_d         = stable_q;
      irq_mask_d     = irq_mask_q;
      rise_en_d      = rise_en_q;
      fall_en_d      = fall_en_q;
      edge_capture_d = edge_capture_q;
      if (w_wr) begin
         case (address)
            c_addr_mask: irq_mask_d     = w_wdata;
            c_addr_edge: edge_capture_d = edge_capture_q & ~w_wdata;
            c_addr_rise: rise_en_d      = w_wdata;
            c_addr_fall: fall_en_d      = w_wdata;
            default:     ;
         endcase
      end
      edge_capture_d = edge_capture_d | w_event;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         c_addr_data: readdata_d[WIDTH-1:0] = stable_q;
         c_addr_sync: readdata_d[WIDTH-1:0] = w_sync;
         c_addr_mask: readdata_d[WIDTH-1:0] = irq_mask_q;
         c_addr_edge: readdata_d[WIDTH-1:0] = edge_capture_q;
         c_addr_rise: readdata_d[WIDTH-1:0] = rise_en_q;
         c_addr_fall: readdata_d[WIDTH-1:0] = fall_en_q;
         default:     readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q         <= '0;
         stable_q       <= '0;
         prev_q         <= '0;
         edge_capture_q <= '0;
         irq_mask_q     <= '0;
         rise_en_q      <= '1;
         fall_en_q      <= '0;
         readdata_q     <= '0;
      end else begin
         sync_q         <= sync_d;
         stable_q       <= stable_d;
         prev_q         <= prev_d;
         edge_capture_q <= edge_capture_d;
         irq_mask_q     <= irq_mask_d;
         rise_en_q      <= rise_en_d;
         fall_en_q      <= fall_en_d;
         readdata_q     <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
`default_nettype wire
